// File: rtl/eggtimer_pkg.sv
// Shared types and digit helpers for the cascaded BCD timer.
// All digit arithmetic is 4-bit BCD bounded by a per-digit maximum.
package eggtimer_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  function automatic logic [BCD_W-1:0] max_digit(input logic [BCD_W-1:0] value,
                                                 input logic [BCD_W-1:0] limit);
    return (value > limit) ? limit : value;
  endfunction

  // One step of a single digit: up wraps limit->0, down wraps 0->limit.
  function automatic logic [BCD_W-1:0] step_digit(input logic [BCD_W-1:0] value,
                                                  input logic [BCD_W-1:0] limit,
                                                  input logic             dir);
    if (dir) begin
      return (value == limit) ? '0 : value + 4'd1;
    end
    return (value == '0) ? limit : value - 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the timer chain: registered digit value with a
// combinational borrow/carry output feeding the next more-significant digit.
module bcd_digit_cell
  import eggtimer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             step_in,
  input  logic             dir,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             reload,
  input  logic [BCD_W-1:0] reload_val,
  input  logic [BCD_W-1:0] limit,
  output logic [BCD_W-1:0] digit,
  output logic             step_out
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (reload) begin
      digit_d = reload_val;
    end else if (step_in) begin
      digit_d = step_digit(digit_q, limit, dir);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  // Borrow (down) or carry (up) only when this digit is about to wrap.
  assign step_out = step_in && (dir ? (digit_q == limit) : (digit_q == '0));
  assign digit    = digit_q;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD timer: digit chain plus start/pause/expire FSM, target
// register, terminal compare and a registered one-cycle done pulse.
module bcd_countdown_timer
  import eggtimer_pkg::*;
#(
  parameter int                          N_DIGITS    = 4,
  parameter logic [BCD_W*N_DIGITS-1:0]   DIGIT_MAX   = 16'h5959,
  parameter logic                        DIRECTION   = 1'b0,
  parameter logic                        AUTO_RELOAD = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      load,
  input  logic                      start,
  input  logic                      pause,
  input  logic [BCD_W*N_DIGITS-1:0] preset,
  output logic [BCD_W*N_DIGITS-1:0] count,
  output logic                      running,
  output logic                      expired,
  output logic                      done
);

  localparam int W = BCD_W * N_DIGITS;

  state_e         state_q;
  logic [W-1:0]   target_q;
  logic           running_q;
  logic           expired_q;
  logic           done_q;

  logic [W-1:0]   clamped_preset;
  logic [W-1:0]   load_val;
  logic [W-1:0]   reload_val;
  logic [W-1:0]   term_val;
  logic [W-1:0]   count_w;
  logic [W-1:0]   next_count;
  logic [N_DIGITS:0] step_chain;

  logic           run_tick;
  logic           at_term;
  logic           do_reload;
  logic           do_step;

  assign term_val   = DIRECTION ? target_q : '0;
  assign at_term    = (count_w == term_val);
  assign load_val   = DIRECTION ? '0 : clamped_preset;
  assign reload_val = DIRECTION ? '0 : target_q;

  // A tick only counts when no higher-priority control input is present.
  assign run_tick  = tick && !load && !pause && !start && (state_q == RUNNING);
  assign do_reload = run_tick && AUTO_RELOAD && at_term;
  assign do_step   = run_tick && !do_reload;

  assign step_chain[0] = do_step;

  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign clamped_preset[gi*BCD_W +: BCD_W] =
        max_digit(preset[gi*BCD_W +: BCD_W], DIGIT_MAX[gi*BCD_W +: BCD_W]);

      // Value the chain will hold after this edge, used for the done compare.
      assign next_count[gi*BCD_W +: BCD_W] =
        do_reload      ? reload_val[gi*BCD_W +: BCD_W] :
        step_chain[gi] ? step_digit(count_w[gi*BCD_W +: BCD_W],
                                    DIGIT_MAX[gi*BCD_W +: BCD_W], DIRECTION) :
                         count_w[gi*BCD_W +: BCD_W];

      bcd_digit_cell u_cell (
        .clk        (clk),
        .reset      (reset),
        .step_in    (step_chain[gi]),
        .dir        (DIRECTION),
        .load       (load),
        .load_val   (load_val[gi*BCD_W +: BCD_W]),
        .reload     (do_reload),
        .reload_val (reload_val[gi*BCD_W +: BCD_W]),
        .limit      (DIGIT_MAX[gi*BCD_W +: BCD_W]),
        .digit      (count_w[gi*BCD_W +: BCD_W]),
        .step_out   (step_chain[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      target_q  <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        target_q  <= clamped_preset;
        state_q   <= IDLE;
        running_q <= 1'b0;
        expired_q <= 1'b0;
      end else if (pause) begin
        if (state_q == RUNNING) begin
          state_q   <= PAUSED;
          running_q <= 1'b0;
        end
      end else if (start) begin
        if ((state_q == IDLE || state_q == PAUSED) && !at_term) begin
          state_q   <= RUNNING;
          running_q <= 1'b1;
        end
      end else if (run_tick) begin
        if (next_count == term_val) begin
          done_q <= 1'b1;
          if (!AUTO_RELOAD) begin
            state_q   <= EXPIRED;
            running_q <= 1'b0;
            expired_q <= 1'b1;
          end
        end
      end
    end
  end

  assign count   = count_w;
  assign running = running_q;
  assign expired = expired_q;
  assign done    = done_q;

endmodule
